// File: rtl/ps2_frame_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard frame receiver.
// Imported by the receiver top and its line filter.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

  // True when the eight data bits plus the parity bit hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// Bundle of PS/2 pin inputs and scan-code outputs for ps2_frame_rx.
// The keyboard side (master) drives the pins; the receiver (slave) drives the results.
interface ps2_frame_rx_if;

  logic       keyb_clk;
  logic       keyb_data;
  logic [7:0] scan_code;
  logic       scan_ready;
  logic       frame_err;

  modport master (
    output keyb_clk,
    output keyb_data,
    input  scan_code,
    input  scan_ready,
    input  frame_err
  );

  modport slave (
    input  keyb_clk,
    input  keyb_data,
    output scan_code,
    output scan_ready,
    output frame_err
  );

endinterface

// File: rtl/ps2_frame_rx_line_filter.sv
// Two-flop synchronizer followed by a deglitch counter for one raw PS/2 line.
// The filtered level idles high and only flips after FILTER_LEN stable opposite samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_FLIP = CW'(FILTER_LEN - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // Synchronize the pin, then count consecutive samples that disagree with the filtered level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      if (sync2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= CNT_FLIP) begin
        filt_q <= sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: filters the pins, assembles 11-bit frames,
// and emits valid bytes with a one-cycle scan_ready strobe. Optional macro: PS2_BREAK_FILTER_EN.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           reset,
  ps2_frame_rx_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  logic          clk_f_s;
  logic          data_f_s;

  logic          clk_prev_q;
  logic          fall_q;
  logic          bit_q;
  ps2_state_e    state_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;
  logic          tmo_hit_s;
  logic [7:0]    scan_code_q;
  logic          scan_ready_q;
  logic          frame_err_q;
`ifdef PS2_BREAK_FILTER_EN
  logic          brk_q;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (bus.keyb_clk),
    .filt_o (clk_f_s)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (bus.keyb_data),
    .filt_o (data_f_s)
  );

  // Inter-edge watchdog: held at zero in IDLE and on every edge, saturates at the limit.
  always_comb begin
    tmo_d     = tmo_q;
    tmo_hit_s = 1'b0;
    if (state_q == IDLE || fall_q) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d     = tmo_q + TW'(1);
      tmo_hit_s = (tmo_q == TMO_MAX - TW'(1));
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Edge detection, frame FSM and registered result strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_prev_q   <= 1'b1;
      fall_q       <= 1'b0;
      bit_q        <= 1'b1;
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      scan_code_q  <= 8'h00;
      scan_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      brk_q        <= 1'b0;
`endif
    end else begin
      clk_prev_q   <= clk_f_s;
      fall_q       <= clk_prev_q & ~clk_f_s;
      bit_q        <= data_f_s;
      tmo_q        <= tmo_d;
      scan_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          // A high start bit is line noise; stay put without flagging it.
          if (fall_q && !bit_q) begin
            state_q <= DATA;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
          end else begin
            state_q <= IDLE;
          end
        end

        DATA: begin
          if (fall_q) begin
            shift_q[idx_q] <= bit_q;
            idx_q          <= idx_q + 3'd1;
            state_q        <= (idx_q == 3'd7) ? PARITY : DATA;
          end else if (tmo_hit_s) begin
            frame_err_q <= 1'b1;
            shift_q     <= 8'h00;
            state_q     <= IDLE;
`ifdef PS2_BREAK_FILTER_EN
            brk_q       <= 1'b0;
`endif
          end else begin
            state_q <= DATA;
          end
        end

        PARITY: begin
          if (fall_q) begin
            par_q   <= bit_q;
            state_q <= STOP;
          end else if (tmo_hit_s) begin
            frame_err_q <= 1'b1;
            shift_q     <= 8'h00;
            state_q     <= IDLE;
`ifdef PS2_BREAK_FILTER_EN
            brk_q       <= 1'b0;
`endif
          end else begin
            state_q <= PARITY;
          end
        end

        STOP: begin
          if (fall_q) begin
            state_q <= IDLE;
            if (bit_q && odd_parity_ok(shift_q, par_q)) begin
`ifdef PS2_BREAK_FILTER_EN
              // F0 arms the filter; the byte after it is swallowed as the released key.
              if (brk_q) begin
                brk_q <= 1'b0;
              end else if (shift_q == PS2_BREAK_CODE) begin
                brk_q <= 1'b1;
              end else begin
                scan_code_q  <= shift_q;
                scan_ready_q <= 1'b1;
              end
`else
              scan_code_q  <= shift_q;
              scan_ready_q <= 1'b1;
`endif
            end else begin
              frame_err_q <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
              brk_q       <= 1'b0;
`endif
            end
          end else if (tmo_hit_s) begin
            frame_err_q <= 1'b1;
            shift_q     <= 8'h00;
            state_q     <= IDLE;
`ifdef PS2_BREAK_FILTER_EN
            brk_q       <= 1'b0;
`endif
          end else begin
            state_q <= STOP;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.scan_code  = scan_code_q;
  assign bus.scan_ready = scan_ready_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: drives PS/2 frames on the raw pins and
// compares strobes against a frame-level reference model (honours PS2_BREAK_FILTER_EN).
module tb_ps2_frame_rx;

  localparam int FL = 8;
  localparam int TO = 3000;
  localparam int H  = 20;

  logic clk = 1'b0;
  logic reset;

  ps2_frame_rx_if bus ();

  ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_fall_cyc = 0;

  logic [7:0] rdy_code_q[$];
  int         rdy_cyc_q[$];
  int         err_cyc_q[$];
  bit         overlap_seen = 1'b0;

  logic [7:0] exp_q[$];
  int         exp_err;
  bit         brk_m;
  logic [7:0] last_emit_m;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.scan_ready === 1'b1) begin
      rdy_code_q.push_back(bus.scan_code);
      rdy_cyc_q.push_back(cyc);
    end
    if (bus.frame_err === 1'b1) err_cyc_q.push_back(cyc);
    if (bus.scan_ready === 1'b1 && bus.frame_err === 1'b1) overlap_seen = 1'b1;
  end

  // Frame-level model: a frame is good iff its stop bit is 1 and its parity was not corrupted.
  function automatic void model_frame(input logic [7:0] d, input bit par_flip, input bit stop);
    if (!stop || par_flip) begin
      exp_err++;
      brk_m = 1'b0;
    end else begin
`ifdef PS2_BREAK_FILTER_EN
      if (brk_m) brk_m = 1'b0;
      else if (d == 8'hF0) brk_m = 1'b1;
      else begin
        exp_q.push_back(d);
        last_emit_m = d;
      end
`else
      exp_q.push_back(d);
      last_emit_m = d;
`endif
    end
  endfunction

  task automatic clear_obs();
    @(negedge clk);
    rdy_code_q.delete();
    rdy_cyc_q.delete();
    err_cyc_q.delete();
    exp_q.delete();
    exp_err = 0;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk);
    bus.keyb_data = b;
    if (glitch) begin
      repeat (11) @(negedge clk);
      bus.keyb_clk = 1'b0;
      repeat (FL - 1) @(negedge clk);
      bus.keyb_clk = 1'b1;
      repeat (H - 11 - (FL - 1)) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    bus.keyb_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (H) @(negedge clk);
    bus.keyb_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop, input int glitch_idx);
    logic par;
    par = (($countones(d) % 2) == 0) ^ par_flip;
    send_bit(1'b0, glitch_idx == 0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch_idx == i + 1);
    send_bit(par, glitch_idx == 9);
    send_bit(stop, glitch_idx == 10);
    @(negedge clk);
    bus.keyb_data = 1'b1;
    model_frame(d, par_flip, stop);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.keyb_clk = 1'b1;
    bus.keyb_data = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (bus.scan_code !== 8'h00) begin
      $display("FAIL reset_scan_code got=%h want=00", bus.scan_code); miscompares++;
    end
    vectors++;
    if (bus.scan_ready !== 1'b0) begin
      $display("FAIL reset_scan_ready got=%b want=0", bus.scan_ready); miscompares++;
    end
    vectors++;
    if (bus.frame_err !== 1'b0) begin
      $display("FAIL reset_frame_err got=%b want=0", bus.frame_err); miscompares++;
    end
    reset = 1'b1;
    brk_m = 1'b0;
    last_emit_m = 8'h00;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_clean();
    clear_obs();
    send_frame(8'h16, 1'b0, 1'b1, -1);
    repeat (FL + 8) @(negedge clk);
    vectors++;
    if (rdy_code_q.size() !== 1) begin
      $display("FAIL clean_ready_count got=%0d want=1", rdy_code_q.size()); miscompares++;
    end else begin
      vectors++;
      if (rdy_code_q[0] !== 8'h16) begin
        $display("FAIL clean_code got=%h want=16", rdy_code_q[0]); miscompares++;
      end
      vectors++;
      if (rdy_cyc_q[0] - last_fall_cyc !== FL + 4) begin
        $display("FAIL clean_latency got=%0d want=%0d", rdy_cyc_q[0] - last_fall_cyc, FL + 4); miscompares++;
      end
    end
    vectors++;
    if (err_cyc_q.size() !== 0) begin
      $display("FAIL clean_err_count got=%0d want=0", err_cyc_q.size()); miscompares++;
    end
  endtask

  task automatic test_parity_err();
    clear_obs();
    send_frame(8'h16, 1'b1, 1'b1, -1);
    repeat (FL + 8) @(negedge clk);
    vectors++;
    if (err_cyc_q.size() !== 1) begin
      $display("FAIL parity_err_count got=%0d want=1", err_cyc_q.size()); miscompares++;
    end
    vectors++;
    if (rdy_code_q.size() !== 0) begin
      $display("FAIL parity_ready_count got=%0d want=0", rdy_code_q.size()); miscompares++;
    end
    vectors++;
    if (bus.scan_code !== last_emit_m) begin
      $display("FAIL parity_code_held got=%h want=%h", bus.scan_code, last_emit_m); miscompares++;
    end
  endtask

  task automatic test_stop_err();
    clear_obs();
    send_frame(8'($urandom), 1'b0, 1'b0, -1);
    repeat (FL + 8) @(negedge clk);
    vectors++;
    if (err_cyc_q.size() !== 1 || rdy_code_q.size() !== 0) begin
      $display("FAIL stop_err got_err=%0d got_rdy=%0d want_err=1 want_rdy=0",
               err_cyc_q.size(), rdy_code_q.size()); miscompares++;
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
    exp_err = 1;
    brk_m = 1'b0;
    repeat (TO + FL + 30) @(negedge clk);
    vectors++;
    if (err_cyc_q.size() !== 1) begin
      $display("FAIL timeout_err_count got=%0d want=1", err_cyc_q.size()); miscompares++;
    end else begin
      vectors++;
      if (err_cyc_q[0] - last_fall_cyc !== FL + 4 + TO) begin
        $display("FAIL timeout_delay got=%0d want=%0d", err_cyc_q[0] - last_fall_cyc, FL + 4 + TO); miscompares++;
      end
    end
    bus.keyb_data = 1'b1;
    clear_obs();
    send_frame(8'h1E, 1'b0, 1'b1, -1);
    repeat (FL + 8) @(negedge clk);
    vectors++;
    if (rdy_code_q.size() !== 1 || err_cyc_q.size() !== 0) begin
      $display("FAIL timeout_recover got_rdy=%0d got_err=%0d want_rdy=1 want_err=0",
               rdy_code_q.size(), err_cyc_q.size()); miscompares++;
    end else begin
      vectors++;
      if (rdy_code_q[0] !== 8'h1E) begin
        $display("FAIL timeout_recover_code got=%h want=1e", rdy_code_q[0]); miscompares++;
      end
    end
  endtask

  task automatic test_glitch();
    clear_obs();
    @(negedge clk);
    bus.keyb_clk = 1'b0;
    repeat (FL - 1) @(negedge clk);
    bus.keyb_clk = 1'b1;
    repeat (30) @(negedge clk);
    send_frame(8'hA5, 1'b0, 1'b1, 4);
    repeat (FL + 8) @(negedge clk);
    vectors++;
    if (rdy_code_q.size() !== 1 || err_cyc_q.size() !== 0) begin
      $display("FAIL glitch_counts got_rdy=%0d got_err=%0d want_rdy=1 want_err=0",
               rdy_code_q.size(), err_cyc_q.size()); miscompares++;
    end else begin
      vectors++;
      if (rdy_code_q[0] !== 8'hA5) begin
        $display("FAIL glitch_code got=%h want=a5", rdy_code_q[0]); miscompares++;
      end
    end
  endtask

  task automatic test_break_seq();
    clear_obs();
    send_frame(8'h16, 1'b0, 1'b1, -1);
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    send_frame(8'h16, 1'b0, 1'b1, -1);
    repeat (FL + 8) @(negedge clk);
    vectors++;
    if (rdy_code_q.size() !== exp_q.size()) begin
      $display("FAIL break_ready_count got=%0d want=%0d", rdy_code_q.size(), exp_q.size()); miscompares++;
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (rdy_code_q[i] !== exp_q[i]) begin
          $display("FAIL break_code[%0d] got=%h want=%h", i, rdy_code_q[i], exp_q[i]); miscompares++;
        end
      end
    end
  endtask

  task automatic test_back_to_back_random();
    logic [7:0] d;
    bit         flip;
    bit         stop;
    int         g;
    clear_obs();
    for (int n = 0; n < 24; n++) begin
      d    = ($urandom_range(0, 5) == 0) ? 8'hF0 : 8'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 9) != 0);
      g    = $urandom_range(0, 20);
      send_frame(d, flip, stop, (g <= 10) ? g : -1);
    end
    repeat (FL + 8) @(negedge clk);
    vectors++;
    if (err_cyc_q.size() !== exp_err) begin
      $display("FAIL random_err_count got=%0d want=%0d", err_cyc_q.size(), exp_err); miscompares++;
    end
    vectors++;
    if (rdy_code_q.size() !== exp_q.size()) begin
      $display("FAIL random_ready_count got=%0d want=%0d", rdy_code_q.size(), exp_q.size()); miscompares++;
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (rdy_code_q[i] !== exp_q[i]) begin
          $display("FAIL random_code[%0d] got=%h want=%h", i, rdy_code_q[i], exp_q[i]); miscompares++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    repeat (FL + 8) @(negedge clk);
    clear_obs();
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.scan_code !== 8'h00 || bus.scan_ready !== 1'b0 || bus.frame_err !== 1'b0) begin
      $display("FAIL midreset_outputs got code=%h rdy=%b err=%b want 00/0/0",
               bus.scan_code, bus.scan_ready, bus.frame_err); miscompares++;
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    bus.keyb_data = 1'b1;
    brk_m = 1'b0;
    last_emit_m = 8'h00;
    repeat (30) @(negedge clk);
    vectors++;
    if (rdy_code_q.size() !== 0 || err_cyc_q.size() !== 0) begin
      $display("FAIL midreset_pulses got_rdy=%0d got_err=%0d want 0/0",
               rdy_code_q.size(), err_cyc_q.size()); miscompares++;
    end
    clear_obs();
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    repeat (FL + 8) @(negedge clk);
    vectors++;
    if (rdy_code_q.size() !== 1) begin
      $display("FAIL midreset_recover_count got=%0d want=1", rdy_code_q.size()); miscompares++;
    end else begin
      vectors++;
      if (rdy_code_q[0] !== 8'h5A) begin
        $display("FAIL midreset_recover_code got=%h want=5a", rdy_code_q[0]); miscompares++;
      end
    end
  endtask

  initial begin
    exp_err = 0;
    test_reset();
    test_clean();
    test_parity_err();
    test_stop_err();
    test_timeout();
    test_glitch();
    test_break_seq();
    test_back_to_back_random();
    test_reset_mid();
    vectors++;
    if (overlap_seen !== 1'b0) begin
      $display("FAIL ready_err_overlap got=1 want=0"); miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

PS/2 device-to-host frame receiver for the keyboard path. Samples the raw keyboard clock and data lines, deglitches them, assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop), and presents each valid byte as a scan code with a one-cycle ready strobe. It feeds the scan-code-to-digit decoder directly. Malformed or stalled frames are flagged and dropped.

## Interface
- FILTER_LEN, 8: consecutive stable `clk` cycles required before the filtered PS/2 clock/data changes level.
- TIMEOUT_CYCLES, 50000: maximum `clk` cycles between filtered falling edges inside a frame before abort.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- keyb_clk  input  1  raw PS/2 clock pin (never driven by this block).
- keyb_data  input  1  raw PS/2 data pin.
- scan_code  output  8  last accepted byte; held until the next accept.
- scan_ready  output  1  one-cycle pulse, same cycle `scan_code` updates.
- frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout failure.

## Operation
- Each raw line passes through a 2-flop synchronizer, then a deglitch counter.
  - Filtered level flips only after FILTER_LEN consecutive cycles at the opposite level.
  - Filtered level resets to 1.
- Falling-edge event: filtered clk was 1 last cycle and is 0 this cycle. Data is sampled from filtered data on that event.
- FSM states and transitions:
  - IDLE: on edge with data 0 → DATA, bit index 0. On edge with data 1 → stays IDLE, no error (treated as noise).
  - DATA: shift bit into position index, LSB first. After index 7 → PARITY.
  - PARITY: capture parity bit → STOP.
  - STOP: on edge, the frame is accepted if stop bit is 1 and the XOR of 8 data bits and parity is 1. Accept: update scan_code, pulse scan_ready. Otherwise pulse frame_err; scan_code unchanged. Either way → IDLE.
- Timeout counter:
  - Cleared on every edge and while in IDLE; counts otherwise.
  - Reaching TIMEOUT_CYCLES in DATA/PARITY/STOP → frame_err pulse, → IDLE, partial byte discarded.
- scan_ready and frame_err are never asserted in the same cycle.
- Reset mid-frame: all state returns to reset values immediately; partial frame lost; no pulses.
- Reset values: scan_code 8'h00, scan_ready 0, frame_err 0, FSM IDLE, counters 0.

## Timing
- Raw pin transition to filtered transition: 2 + FILTER_LEN cycles.
- Edge event registers 1 cycle later.
- scan_ready asserts the cycle after the STOP-state edge event.
  - Total from raw stop-bit clock fall: FILTER_LEN + 4 cycles.
- Timeout pulse: the cycle the counter reaches TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES cycles after the last edge.
- Counter width: $clog2(TIMEOUT_CYCLES+1). Filter counter width: $clog2(FILTER_LEN+1). Neither counter wraps; both saturate.
- Back-to-back frames need no idle gap beyond the protocol's own; IDLE accepts a start edge the cycle after STOP.

## Configuration
- PS2_BREAK_FILTER_EN defined:
  - Accepted byte 8'hF0 sets break_pending and is not emitted.
  - The next accepted byte clears break_pending and is not emitted.
  - No scan_ready occurs for either byte.
  - frame_err or timeout also clears break_pending.
  - 8'hE0 passes through unchanged.
- Undefined: every accepted byte, including F0, is emitted with scan_ready.

## Structure
- Package ps2_pkg:
  - FSM state enum: IDLE, DATA, PARITY, STOP.
  - Constants: PS2_BREAK_CODE = 8'hF0, PS2_EXT_CODE = 8'hE0.
- Sub-module ps2_line_filter (synchronizer + deglitch, parameter FILTER_LEN), instantiated once for clock and once for data.

## Test plan
- Clean frame for 8'h16 (data bits 0110_1000 LSB-first, parity 0, stop 1) → one scan_ready pulse, scan_code = 8'h16, frame_err 0.
- Same frame with parity flipped to 1 → frame_err one pulse, no scan_ready, scan_code keeps previous value.
- Clock stops after 4 data bits → frame_err exactly TIMEOUT_CYCLES cycles after the last edge. A following frame 8'h1E is then accepted.
- Glitch pulses of FILTER_LEN−1 cycles on keyb_clk in IDLE and mid-frame → no extra bits, no pulses. Byte is received correctly.
- Sequence 8'h16, 8'hF0, 8'h16:
  - With PS2_BREAK_FILTER_EN → one scan_ready (first 8'h16).
  - Without → three scan_ready pulses, values 16, F0, 16.
- Reset asserted after 5 data bits → all outputs 0 immediately. A new full frame after release is received correctly.
